// File: rtl/dcache_pkg.sv
// Shared types and constants for the data-cache refill unit.
// Holds the refill FSM encoding plus the block/word geometry helpers.
package dcache_pkg;

  localparam int BLOCK_BITS  = 128;
  localparam int WORD_BITS   = 32;
  localparam int OFFSET_BITS = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB      = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Byte address of beat cnt inside an aligned block.
  function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [1:0] cnt);
    return base + {28'd0, cnt, 2'b00};
  endfunction

  // Bit position of word cnt inside a block.
  function automatic logic [6:0] word_lsb(input logic [1:0] cnt);
    return {cnt, 5'd0};
  endfunction

endpackage

// File: rtl/dcache_refill_unit_if.sv
// Single-beat memory bus between the refill unit (master) and the memory (slave).
interface dcache_refill_unit_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/dcache_refill_unit.sv
// Refill engine: optional 4-beat victim write-back, then 4 single-outstanding
// read beats, then a one-cycle repair_resolved pulse. All outputs are registered.
module dcache_refill_unit #(
  parameter int BEATS       = 4,
  parameter int OFFSET_BITS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              read_miss_repair,
  input  logic                              write_miss_repair,
  input  logic [31:0]                       missed_addr,
  input  logic                              evict_valid,
  input  logic [31:0]                       evict_addr,
  input  logic [dcache_pkg::BLOCK_BITS-1:0] evict_data,
  output logic                              repair_resolved,
  output logic [31:0]                       fill_addr,
  output logic [dcache_pkg::BLOCK_BITS-1:0] fill_data,
  dcache_refill_unit_if.master              mem
);
  import dcache_pkg::*;

  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);
  localparam logic [1:0]  LAST_BEAT  = 2'(BEATS - 1);

  state_t                state_r, state_s;
  logic [1:0]            cnt_r, cnt_s;
  logic [31:0]           base_r, base_s;
  logic [31:0]           victim_addr_r, victim_addr_s;
  logic [BLOCK_BITS-1:0] victim_data_r, victim_data_s;
  logic                  repair_resolved_s;
  logic [31:0]           fill_addr_s;
  logic [BLOCK_BITS-1:0] fill_data_s;
  logic                  mem_req_s;
  logic                  mem_we_s;
  logic [31:0]           mem_addr_s;
  logic [31:0]           mem_wdata_s;

  // Next-state logic, then outputs decoded from the next state so they register in step with it.
  always_comb begin
    state_s           = state_r;
    cnt_s             = cnt_r;
    base_s            = base_r;
    victim_addr_s     = victim_addr_r;
    victim_data_s     = victim_data_r;
    fill_addr_s       = fill_addr;
    fill_data_s       = fill_data;
    repair_resolved_s = 1'b0;
    mem_req_s         = 1'b0;
    mem_we_s          = 1'b0;
    mem_addr_s        = 32'd0;
    mem_wdata_s       = 32'd0;

    case (state_r)
      S_IDLE: begin
        if (read_miss_repair || write_miss_repair) begin
          base_s        = missed_addr & ALIGN_MASK;
          victim_addr_s = evict_addr & ALIGN_MASK;
          victim_data_s = evict_data;
          cnt_s         = 2'd0;
          state_s       = evict_valid ? S_WB : S_RD_REQ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WB: begin
        if (mem.mem_ready) begin
          if (cnt_r == LAST_BEAT) begin
            cnt_s   = 2'd0;
            state_s = S_RD_REQ;
          end else begin
            cnt_s = cnt_r + 2'd1;
          end
        end else begin
          state_s = S_WB;
        end
      end
      S_RD_REQ: begin
        // rvalid is deliberately ignored here: only one read is ever outstanding.
        if (mem.mem_ready) begin
          state_s = S_RD_WAIT;
        end else begin
          state_s = S_RD_REQ;
        end
      end
      S_RD_WAIT: begin
        if (mem.mem_rvalid) begin
          fill_data_s[word_lsb(cnt_r) +: WORD_BITS] = mem.mem_rdata;
          if (cnt_r == LAST_BEAT) begin
            state_s = S_DONE;
          end else begin
            cnt_s   = cnt_r + 2'd1;
            state_s = S_RD_REQ;
          end
        end else begin
          state_s = S_RD_WAIT;
        end
      end
      S_DONE: begin
        cnt_s   = 2'd0;
        state_s = S_IDLE;
      end
      default: begin
        cnt_s   = 2'd0;
        state_s = S_IDLE;
      end
    endcase

    case (state_s)
      S_WB: begin
        mem_req_s   = 1'b1;
        mem_we_s    = 1'b1;
        mem_addr_s  = beat_addr(victim_addr_s, cnt_s);
        mem_wdata_s = victim_data_s[word_lsb(cnt_s) +: WORD_BITS];
      end
      S_RD_REQ: begin
        mem_req_s  = 1'b1;
        mem_addr_s = beat_addr(base_s, cnt_s);
      end
      S_DONE: begin
        repair_resolved_s = 1'b1;
        fill_addr_s       = base_s;
      end
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

  // State, latched request context and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= S_IDLE;
      cnt_r           <= 2'd0;
      base_r          <= 32'd0;
      victim_addr_r   <= 32'd0;
      victim_data_r   <= '0;
      repair_resolved <= 1'b0;
      fill_addr       <= 32'd0;
      fill_data       <= '0;
      mem.mem_req     <= 1'b0;
      mem.mem_we      <= 1'b0;
      mem.mem_addr    <= 32'd0;
      mem.mem_wdata   <= 32'd0;
    end else begin
      state_r         <= state_s;
      cnt_r           <= cnt_s;
      base_r          <= base_s;
      victim_addr_r   <= victim_addr_s;
      victim_data_r   <= victim_data_s;
      repair_resolved <= repair_resolved_s;
      fill_addr       <= fill_addr_s;
      fill_data       <= fill_data_s;
      mem.mem_req     <= mem_req_s;
      mem.mem_we      <= mem_we_s;
      mem.mem_addr    <= mem_addr_s;
      mem.mem_wdata   <= mem_wdata_s;
    end
  end

endmodule

// File: tb/tb_dcache_refill_unit.sv
// Scoreboard bench for dcache_refill_unit: directed misses against a simple
// memory responder; a negedge monitor checks every beat and every fill.
module tb_dcache_refill_unit;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  logic         clk;
  logic         rst;
  logic         read_miss_repair;
  logic         write_miss_repair;
  logic [31:0]  missed_addr;
  logic         evict_valid;
  logic [31:0]  evict_addr;
  logic [127:0] evict_data;
  logic         repair_resolved;
  logic [31:0]  fill_addr;
  logic [127:0] fill_data;

  dcache_refill_unit_if mem_bus ();

  dcache_refill_unit #(.BEATS(4), .OFFSET_BITS(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .read_miss_repair  (read_miss_repair),
    .write_miss_repair (write_miss_repair),
    .missed_addr       (missed_addr),
    .evict_valid       (evict_valid),
    .evict_addr        (evict_addr),
    .evict_data        (evict_data),
    .repair_resolved   (repair_resolved),
    .fill_addr         (fill_addr),
    .fill_data         (fill_data),
    .mem               (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t        exp_beats[$];
  logic [31:0]  exp_faddr[$];
  logic [127:0] exp_fdata[$];
  int n_checks = 0;
  int n_fail = 0;
  int fills_seen = 0;
  int reads_seen = 0;
  int stall = 0;
  int inject_req = 0;
  int inject_done = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Expected traffic for one refill: optional write-back, four reads, one fill.
  task automatic exp_block(input logic [31:0] base, input bit ev, input logic [31:0] vaddr,
                           input logic [127:0] vdata);
    logic [127:0] fd;
    if (ev) begin
      for (int i = 0; i < 4; i++) exp_beats.push_back('{1'b1, vaddr + 32'(4 * i), vdata[32*i +: 32]});
    end
    for (int i = 0; i < 4; i++) begin
      exp_beats.push_back('{1'b0, base + 32'(4 * i), 32'h0});
      fd[32*i +: 32] = mem_word(base + 32'(4 * i));
    end
    exp_faddr.push_back(base);
    exp_fdata.push_back(fd);
  endtask

  // Memory responder: configurable ready stall, read data one cycle after acceptance.
  initial begin
    logic acc;
    logic acc_we;
    logic [31:0] acc_addr;
    int wait_cnt;
    wait_cnt = 0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      acc = mem_bus.mem_req && mem_bus.mem_ready;
      acc_we = mem_bus.mem_we;
      acc_addr = mem_bus.mem_addr;
      @(posedge clk);
      #1;
      if (inject_req != inject_done) begin
        inject_done = inject_req;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata = 32'hBAD0_BAD0;
      end else begin
        mem_bus.mem_rvalid = acc && !acc_we;
        mem_bus.mem_rdata = (acc && !acc_we) ? mem_word(acc_addr) : 32'h0;
      end
      if (acc) wait_cnt = 0;
      if (mem_bus.mem_req) begin
        if (wait_cnt >= stall) begin
          mem_bus.mem_ready = 1'b1;
        end else begin
          mem_bus.mem_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_bus.mem_ready = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted beat and every fill pulse.
  initial begin
    logic prev_req, prev_acc, prev_rr;
    beat_t prev_beat, cur, exp;
    prev_req = 1'b0; prev_acc = 1'b0; prev_rr = 1'b0; prev_beat = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0; prev_acc = 1'b0; prev_rr = 1'b0;
      end else begin
        cur = '{mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata};
        if (!mem_bus.mem_req) chk("idle_we_wdata", {mem_bus.mem_we, mem_bus.mem_wdata}, 160'h0);
        if (prev_req && !prev_acc) chk("stall_stable", {mem_bus.mem_req, cur}, {1'b1, prev_beat});
        if (mem_bus.mem_req && mem_bus.mem_ready) begin
          if (!mem_bus.mem_we) reads_seen++;
          if (exp_beats.size() == 0) begin
            chk("unexpected_beat", {cur.we, cur.addr}, 160'h0);
            if (!cur.we && cur.addr == 32'h0) chk("unexpected_beat_zero", 160'h1, 160'h0);
          end else begin
            exp = exp_beats.pop_front();
            chk("mem_beat", {cur.we, cur.addr, cur.we ? cur.wdata : 32'h0}, exp);
          end
        end
        if (repair_resolved) begin
          fills_seen++;
          chk("pulse_width", prev_rr, 160'h0);
          if (exp_faddr.size() == 0) begin
            chk("unexpected_fill", 160'h1, 160'h0);
          end else begin
            chk("fill_addr", fill_addr, exp_faddr.pop_front());
            chk("fill_data", fill_data, exp_fdata.pop_front());
          end
        end
        prev_req = mem_bus.mem_req;
        prev_acc = mem_bus.mem_req && mem_bus.mem_ready;
        prev_beat = cur;
        prev_rr = repair_resolved;
      end
    end
  end

  task automatic outputs_zero(input string tag);
    chk({tag, "_repair_resolved"}, repair_resolved, 160'h0);
    chk({tag, "_fill_addr"}, fill_addr, 160'h0);
    chk({tag, "_fill_data"}, fill_data, 160'h0);
    chk({tag, "_mem_req"}, mem_bus.mem_req, 160'h0);
    chk({tag, "_mem_we"}, mem_bus.mem_we, 160'h0);
    chk({tag, "_mem_addr"}, mem_bus.mem_addr, 160'h0);
    chk({tag, "_mem_wdata"}, mem_bus.mem_wdata, 160'h0);
  endtask

  // Issue a request (held until nfills fills seen, or a one-cycle pulse) and wait, bounded.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr, input logic ev,
                        input logic [31:0] eaddr, input logic [127:0] edata, input bit hold,
                        input int nfills);
    int target;
    bit done;
    target = fills_seen + nfills;
    done = 1'b0;
    @(posedge clk); #1;
    read_miss_repair = rd; write_miss_repair = wr; missed_addr = addr;
    evict_valid = ev; evict_addr = eaddr; evict_data = edata;
    if (!hold) begin
      @(posedge clk); #1;
      read_miss_repair = 1'b0; write_miss_repair = 1'b0; evict_valid = 1'b0;
    end
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #2;
      if (fills_seen >= target) done = 1'b1;
    end
    read_miss_repair = 1'b0; write_miss_repair = 1'b0; evict_valid = 1'b0;
    chk("fill_done", done, 160'h1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    bit hit;
    rst = 1'b1;
    read_miss_repair = 1'b0; write_miss_repair = 1'b0; missed_addr = 32'h0;
    evict_valid = 1'b0; evict_addr = 32'h0; evict_data = 128'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Plain read miss, zero-wait memory, request held until the fill.
    exp_block(32'h0000_1230, 1'b0, 32'h0, 128'h0);
    do_req(1'b1, 1'b0, 32'h0000_1234, 1'b0, 32'h0, 128'h0, 1'b1, 1);

    // Write miss with dirty victim (unaligned victim address is cleared).
    exp_block(32'h0000_4560, 1'b1, 32'h0000_8000,
              {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0});
    do_req(1'b0, 1'b1, 32'h0000_4560, 1'b1, 32'h0000_8008,
           {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0}, 1'b0, 1);

    // Three-cycle ready stall on every beat.
    stall = 3;
    exp_block(32'h0000_ABC0, 1'b1, 32'h0000_2220,
              {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000});
    do_req(1'b1, 1'b0, 32'h0000_ABC4, 1'b1, 32'h0000_2224,
           {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000}, 1'b1, 1);
    stall = 0;

    // Both repair inputs together: exactly one refill.
    exp_block(32'h0000_7770, 1'b0, 32'h0, 128'h0);
    do_req(1'b1, 1'b1, 32'h0000_7778, 1'b0, 32'h0, 128'h0, 1'b0, 1);

    // Top-of-address-space block.
    exp_block(32'hFFFF_FFF0, 1'b0, 32'h0, 128'h0);
    do_req(1'b1, 1'b0, 32'hFFFF_FFF8, 1'b0, 32'h0, 128'h0, 1'b0, 1);

    // Request still high after DONE starts a second refill.
    exp_block(32'h0000_3000, 1'b0, 32'h0, 128'h0);
    exp_block(32'h0000_3000, 1'b0, 32'h0, 128'h0);
    do_req(1'b1, 1'b0, 32'h0000_3004, 1'b0, 32'h0, 128'h0, 1'b1, 2);

    // Reset while waiting for read beat 2: no fill, late rvalid ignored.
    for (int i = 0; i < 3; i++) exp_beats.push_back('{1'b0, 32'h0000_5550 + 32'(4 * i), 32'h0});
    @(posedge clk); #1;
    read_miss_repair = 1'b1; missed_addr = 32'h0000_5554;
    @(posedge clk); #1;
    read_miss_repair = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #2;
      if (reads_seen >= 3 * 4 + 3 + 4 * 4) hit = 1'b1;
    end
    chk("rst_test_reached_beat2", hit, 160'h1);
    rst = 1'b1;
    @(negedge clk);
    inject_req++;
    @(negedge clk);
    outputs_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("late_rvalid_fill_data", fill_data, 160'h0);
    chk("late_rvalid_no_req", mem_bus.mem_req, 160'h0);

    // Clean refill after the abandoned one.
    exp_block(32'h0000_5550, 1'b0, 32'h0, 128'h0);
    do_req(1'b1, 1'b0, 32'h0000_5554, 1'b0, 32'h0, 128'h0, 1'b0, 1);

    repeat (5) @(posedge clk);
    chk("beats_left", 160'(exp_beats.size()), 160'h0);
    chk("fills_left", 160'(exp_faddr.size()), 160'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dcache_refill_unit.md
DCACHE_REFILL_UNIT -- requirements
Module: dcache_refill_unit

Interface
REQ-001 SHALL have parameter BEATS, default 4, number of 32-bit memory beats per 128-bit block; only 4 supported.
REQ-002 SHALL have parameter OFFSET_BITS, default 4, block byte-offset width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 read_miss_repair  in  1  level request from cache controller: read miss pending.
REQ-006 write_miss_repair  in  1  level request from cache controller: write miss pending.
REQ-007 missed_addr  in  32  byte address of missing block; valid while either repair request is high.
REQ-008 evict_valid  in  1  victim block is dirty; sampled with the request.
REQ-009 evict_addr  in  32  victim block byte address.
REQ-010 evict_data  in  128  victim block data; word i at bits [32i+31:32i].
REQ-011 repair_resolved  out  1  one-cycle pulse: fill_data/fill_addr valid, cache may write block.
REQ-012 fill_addr  out  32  block-aligned address of filled block.
REQ-013 fill_data  out  128  refilled block; beat i at bits [32i+31:32i].
REQ-014 mem_req  out  1  memory beat request, held until mem_ready.
REQ-015 mem_we  out  1  1 = write beat, 0 = read beat.
REQ-016 mem_addr  out  32  word-aligned beat address.
REQ-017 mem_wdata  out  32  write beat data.
REQ-018 mem_ready  in  1  memory accepts beat in the cycle mem_req && mem_ready.
REQ-019 mem_rvalid  in  1  read data beat valid; at most one outstanding read.
REQ-020 mem_rdata  in  32  read beat data.

Function
REQ-021 FSM states IDLE, WB, RD_REQ, RD_WAIT, DONE.
REQ-022 IDLE: when (read_miss_repair || write_miss_repair), latch base = missed_addr with [3:0] cleared and victim = evict_addr/evict_data with [3:0] cleared; go WB if evict_valid, else RD_REQ; beat counter cleared.
REQ-023 Both repair inputs high in one cycle SHALL yield exactly one refill of missed_addr's block.
REQ-024 WB: mem_req=1, mem_we=1, mem_addr=victim+4*cnt, mem_wdata=victim word cnt; on mem_ready, cnt++; after beat 3 accepted, cnt=0, go RD_REQ.
REQ-025 RD_REQ: mem_req=1, mem_we=0, mem_addr=base+4*cnt; on mem_ready go RD_WAIT.
REQ-026 RD_WAIT: mem_req=0; on mem_rvalid, write mem_rdata into fill_data word cnt; if cnt==3 go DONE, else cnt++ and go RD_REQ.
REQ-027 mem_rvalid in the same cycle as mem_ready acceptance SHALL be ignored; data accepted only in RD_WAIT.
REQ-028 DONE: repair_resolved=1 for exactly one cycle, fill_addr=base, fill_data complete; next state IDLE.
REQ-029 Requests re-sampled only in IDLE; a request still high in the cycle after DONE starts a new refill.
REQ-030 Request deassertion mid-operation SHALL NOT abort the sequence.
REQ-031 Address arithmetic 32-bit, wraps modulo 2^32.
REQ-032 mem_req low in IDLE, RD_WAIT, DONE; mem_we and mem_wdata 0 whenever mem_req low.
REQ-033 Latency without eviction and zero-wait memory (mem_ready=1, rvalid one cycle after acceptance): repair_resolved 9 cycles after request sampled.

Reset
REQ-034 On rst, state=IDLE, cnt=0, repair_resolved=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, fill_addr=0, fill_data=0.
REQ-035 rst mid-operation SHALL abandon the transfer without a repair_resolved pulse; a pending read response arriving after reset is ignored.

Structure
REQ-036 State enum, BLOCK_BITS=128, WORD_BITS=32, OFFSET_BITS SHALL live in shared package dcache_pkg.
REQ-037 Single flat module; no sub-modules.

Verification
REQ-038 Read miss, missed_addr=0x0000_1234, evict_valid=0, zero-wait memory -> reads at 0x1230,0x1234,0x1238,0x123C; fill_addr=0x1230; repair_resolved pulse once.
REQ-039 Write miss with evict_valid=1, evict_addr=0x0000_8000, evict_data words 0xA0..0xA3 -> four writes 0x8000..0x800C with data 0xA0..0xA3 before first read.
REQ-040 mem_ready held low 3 cycles per beat -> mem_req/mem_addr stable while stalled; fill_data correct.
REQ-041 Both repair inputs high simultaneously -> exactly one 4-beat read, one repair_resolved pulse.
REQ-042 rst asserted in RD_WAIT of beat 2 -> all outputs reset next cycle, no repair_resolved; later request refills cleanly.
REQ-043 missed_addr=0xFFFF_FFF8 -> beat addresses 0xFFFFFFF0..0xFFFFFFFC, no overflow into next block.
